// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the memory port arbiter
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// rtl/mem_arb_starve_ctr.sv - saturating count of arbitrations lost by the DMA requester
module mem_arb_starve_ctr #(
   parameter  int MAX = 4,
   localparam int CW  = $clog2(MAX + 1)
) (
   input  logic clock,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign sat = (cnt_q == CW'(MAX));

   // Clear wins over increment; increment stops at MAX.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && !sat) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Count register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - CPU/DMA arbiter onto one fixed-latency memory strobe port
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_ack,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner
);

   localparam int              LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

   state_e              state_q, state_d;
   logic [LAT_W-1:0]    lat_q, lat_d;
   owner_e              owner_q, owner_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;

   logic in_idle;
   logic any_req;
   logic grant_dma;
   logic starve_sat;
   logic starve_inc;
   logic starve_clr;

   assign in_idle   = (state_q == ST_IDLE);
   assign any_req   = cpu_req | dma_req;
   // CPU has priority unless DMA has lost STARVE_MAX arbitrations in a row.
   assign grant_dma = dma_req & (~cpu_req | starve_sat);

   // A lost arbitration is an idle decision where DMA asked but CPU won.
   assign starve_inc = in_idle & dma_req & ~grant_dma;
   assign starve_clr = in_idle & (~dma_req | grant_dma);

   mem_arb_starve_ctr #(
      .MAX (STARVE_MAX)
   ) u_starve (
      .clock (clock),
      .reset (reset),
      .inc   (starve_inc),
      .clr   (starve_clr),
      .sat   (starve_sat)
   );

   // Next-state, transaction latch and read-data capture.
   always_comb begin
      state_d     = state_q;
      lat_d       = lat_q;
      owner_d     = owner_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      dma_rdata_d = dma_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               owner_d = grant_dma ? OWN_DMA : OWN_CPU;
               we_d    = grant_dma ? dma_we    : cpu_we;
               addr_d  = grant_dma ? dma_addr  : cpu_addr;
               wdata_d = grant_dma ? dma_wdata : cpu_wdata;
               lat_d   = LAT_LOAD;
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (lat_q == '0) begin
               state_d = ST_RESP;
               if (!we_q) begin
                  if (owner_q == OWN_DMA) begin
                     dma_rdata_d = mem_rdata;
                  end else begin
                     cpu_rdata_d = mem_rdata;
                  end
               end
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any in-flight transaction.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         lat_q       <= '0;
         owner_q     <= OWN_CPU;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         lat_q       <= lat_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
      end
   end

   assign mem_read  = (state_q == ST_ACCESS) & ~we_q;
   assign mem_write = (state_q == ST_ACCESS) &  we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign cpu_ack   = (state_q == ST_RESP) & (owner_q == OWN_CPU);
   assign dma_ack   = (state_q == ST_RESP) & (owner_q == OWN_DMA);
   assign cpu_rdata = cpu_rdata_q;
   assign dma_rdata = dma_rdata_q;
   assign busy      = (state_q == ST_ACCESS) | (state_q == ST_RESP);
   assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

   localparam int LAT  = 2;
   localparam int SMAX = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0;
   logic        cpu_ack;
   logic [31:0] cpu_rdata;
   logic        dma_req = 1'b0, dma_we = 1'b0;
   logic [31:0] dma_addr = '0, dma_wdata = '0;
   logic        dma_ack;
   logic [31:0] dma_rdata;
   logic        mem_read, mem_write;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        busy, owner;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
   ) dut (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ack(dma_ack), .dma_rdata(dma_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy), .owner(owner)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Transaction-level model: m_k counts cycles since the grant edge
   // (0 = idle, 1..LAT = strobe cycles, LAT+1 = ack cycle).
   int          m_k = 0;
   int          m_starve = 0;
   logic        m_dma = 1'b0, m_we = 1'b0;
   logic [31:0] m_addr = '0, m_wdata = '0, m_crd = '0, m_drd = '0;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_k = 0; m_starve = 0; m_dma = 1'b0; m_we = 1'b0;
         m_addr = '0; m_wdata = '0; m_crd = '0; m_drd = '0;
      end else if (m_k == 0) begin
         if (cpu_req || dma_req) begin
            m_dma   = dma_req && (!cpu_req || m_starve == SMAX);
            m_starve = (m_dma || !dma_req) ? 0 : ((m_starve < SMAX) ? m_starve + 1 : SMAX);
            m_we    = m_dma ? dma_we    : cpu_we;
            m_addr  = m_dma ? dma_addr  : cpu_addr;
            m_wdata = m_dma ? dma_wdata : cpu_wdata;
            m_k     = 1;
         end else begin
            m_starve = 0;
         end
      end else if (m_k <= LAT) begin
         if (m_k == LAT && !m_we) begin
            if (m_dma) m_drd = mem_rdata;
            else       m_crd = mem_rdata;
         end
         m_k = m_k + 1;
      end else begin
         m_k = 0;
      end
   end

   // Compare every DUT output against the model on the falling edge.
   always @(negedge clock) begin
      check("mem_read",  64'(mem_read),  64'(m_k >= 1 && m_k <= LAT && !m_we));
      check("mem_write", 64'(mem_write), 64'(m_k >= 1 && m_k <= LAT &&  m_we));
      check("mem_addr",  64'(mem_addr),  64'(m_addr));
      check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
      check("cpu_ack",   64'(cpu_ack),   64'(m_k == LAT + 1 && !m_dma));
      check("dma_ack",   64'(dma_ack),   64'(m_k == LAT + 1 &&  m_dma));
      check("cpu_rdata", 64'(cpu_rdata), 64'(m_crd));
      check("dma_rdata", 64'(dma_rdata), 64'(m_drd));
      check("busy",      64'(busy),      64'(m_k != 0));
      check("owner",     64'(owner),     64'(m_dma));
   end

   // Snapshot of the last transaction as seen by the requester.
   int          s_lat, s_strobes;
   logic        s_rd, s_wr;
   logic [31:0] s_addr, s_wdata, s_ack_addr;

   // mode: 0 plain, 1 change cpu_addr during access, 2 pulse dma_req during access
   task automatic do_txn(input bit is_dma, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int mode);
      int  start;
      bit  done;
      @(posedge clock); #1;
      mem_rdata = rdata;
      if (is_dma) begin
         dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
      end else begin
         cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      end
      start = cyc; s_strobes = 0; s_lat = -1; done = 1'b0;
      s_rd = 1'b0; s_wr = 1'b0; s_addr = '0; s_wdata = '0; s_ack_addr = '0;
      for (int i = 0; i < 30 && !done; i++) begin
         @(posedge clock); #1;
         if (mem_read || mem_write) begin
            if (s_strobes == 0) begin
               s_rd = mem_read; s_wr = mem_write; s_addr = mem_addr; s_wdata = mem_wdata;
               if (mode == 1) cpu_addr = 32'h80;
               if (mode == 2) dma_req = 1'b1;
            end else if (mode == 2) begin
               dma_req = 1'b0;
            end
            s_strobes++;
         end
         if ((is_dma && dma_ack) || (!is_dma && cpu_ack)) begin
            s_lat = cyc - start;
            s_ack_addr = mem_addr;
            if (is_dma) dma_req = 1'b0; else cpu_req = 1'b0;
            done = 1'b1;
         end
      end
      if (!done) begin
         total++; bad++;
         $display("FAIL ack_timeout: got no ack want ack within 30 cycles");
         cpu_req = 1'b0; dma_req = 1'b0;
      end
   endtask

   task automatic count_acks(input int n, output int c_acks, output int d_acks);
      c_acks = 0; d_acks = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clock); #1;
         if (cpu_ack) c_acks++;
         if (dma_ack) d_acks++;
      end
   endtask

   initial begin
      int ca, da, grants, d_idx0, d_idx1, dcount;
      bit fin;

      // Reset state.
      repeat (2) @(posedge clock);
      #1;
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_mem_addr", 64'(mem_addr), 64'(0));
      reset = 1'b0;

      // Reset in the first strobe cycle of a CPU read.
      @(posedge clock); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; mem_rdata = 32'h1111_2222;
      @(posedge clock); #1;
      check("pre_rst_mem_read", 64'(mem_read), 64'(1));
      #2 reset = 1'b1;
      #1;
      check("async_rst_mem_read", 64'(mem_read), 64'(0));
      check("async_rst_busy", 64'(busy), 64'(0));
      cpu_req = 1'b0;
      @(posedge clock); #1 reset = 1'b0;
      count_acks(6, ca, da);
      check("rst_no_cpu_ack", 64'(ca), 64'(0));
      check("rst_rdata_kept0", 64'(cpu_rdata), 64'(0));

      // CPU read.
      do_txn(1'b0, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 0);
      check("cpu_rd_latency", 64'(s_lat), 64'(LAT + 1));
      check("cpu_rd_strobes", 64'(s_strobes), 64'(LAT));
      check("cpu_rd_strobe_is_read", 64'({s_rd, s_wr}), 64'(2'b10));
      check("cpu_rd_addr", 64'(s_addr), 64'(32'h40));
      check("cpu_rd_data", 64'(cpu_rdata), 64'(32'hDEAD_BEEF));

      // DMA write.
      do_txn(1'b1, 1'b1, 32'h100, 32'h1234_5678, 32'hFFFF_FFFF, 0);
      check("dma_wr_latency", 64'(s_lat), 64'(LAT + 1));
      check("dma_wr_strobes", 64'(s_strobes), 64'(LAT));
      check("dma_wr_strobe_is_write", 64'({s_rd, s_wr}), 64'(2'b01));
      check("dma_wr_addr", 64'(s_addr), 64'(32'h100));
      check("dma_wr_wdata", 64'(s_wdata), 64'(32'h1234_5678));
      check("dma_wr_owner", 64'(owner), 64'(1));
      check("dma_wr_rdata_unchanged", 64'(dma_rdata), 64'(0));

      // CPU address changes while the access is in flight.
      do_txn(1'b0, 1'b0, 32'h40, 32'h0, 32'hCAFE_0001, 1);
      check("chg_addr_first", 64'(s_addr), 64'(32'h40));
      check("chg_addr_at_ack", 64'(s_ack_addr), 64'(32'h40));
      check("chg_addr_rdata", 64'(cpu_rdata), 64'(32'hCAFE_0001));

      // DMA request pulsed and dropped while the CPU owns the port.
      do_txn(1'b0, 1'b1, 32'h44, 32'h5555_AAAA, 32'h0, 2);
      count_acks(6, ca, da);
      check("early_drop_no_dma_ack", 64'(da), 64'(0));

      // Both requesting continuously: expect CCCCD CCCCD.
      @(posedge clock); #1;
      mem_rdata = 32'hA5A5_0001;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h200;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h300;
      grants = 0; dcount = 0; d_idx0 = -1; d_idx1 = -1; fin = 1'b0;
      for (int i = 0; i < 100 && !fin; i++) begin
         @(posedge clock); #1;
         if (cpu_ack) grants++;
         if (dma_ack) begin
            if (dcount == 0) d_idx0 = grants; else d_idx1 = grants;
            grants++; dcount++;
            if (dcount == 2) begin
               cpu_req = 1'b0; dma_req = 1'b0; fin = 1'b1;
            end
         end
      end
      cpu_req = 1'b0; dma_req = 1'b0;
      check("starve_first_dma_grant", 64'(d_idx0), 64'(SMAX));
      check("starve_second_dma_grant", 64'(d_idx1), 64'(2 * SMAX + 1));
      check("starve_cpu_rdata", 64'(cpu_rdata), 64'(32'hA5A5_0001));
      check("starve_dma_rdata", 64'(dma_rdata), 64'(32'hA5A5_0001));

      // DMA read after idle.
      do_txn(1'b1, 1'b0, 32'h304, 32'h0, 32'h0BAD_F00D, 0);
      check("dma_rd_data", 64'(dma_rdata), 64'(32'h0BAD_F00D));
      check("dma_rd_cpu_untouched", 64'(cpu_rdata), 64'(32'hA5A5_0001));

      repeat (3) @(posedge clock);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified instruction/data memory port between the multicycle CPU control path and a DMA/loader requester. Each requester issues single-word read or write transactions over a req/ack handshake. The block serialises them onto one memory strobe interface with a fixed access latency. CPU has fixed priority; a starvation counter guarantees DMA forward progress.

Parameters:
ADDR_W, 32, address width of both requesters and memory port
DATA_W, 32, data width
MEM_LAT, 2, memory access cycles per transaction (strobe held this many cycles; >=1)
STARVE_MAX, 4, consecutive lost arbitrations after which DMA wins over CPU (>=1)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU transaction request, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ack, held until next CPU read ack
dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rdata  same as CPU set, for DMA
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid in last strobe cycle
busy  out  1  high in ST_ACCESS and ST_RESP
owner  out  1  0 = CPU, 1 = DMA; current/last grantee

Behaviour:
- Reset (async, active-high): all outputs 0, state ST_IDLE, starvation count 0, latency counter 0; an in-flight transaction is discarded with no ack and strobes drop immediately.
- States: ST_IDLE -> ST_ACCESS -> ST_RESP -> ST_IDLE. No other transitions.
- ST_IDLE: if no req, stay. Otherwise pick a winner, latch its we/addr/wdata into mem_* registers, set owner, load latency counter with MEM_LAT-1, and go to ST_ACCESS. Strobes rise the cycle after the req is sampled.
- Winner rule: DMA if dma_req and (not cpu_req or starve_cnt == STARVE_MAX); else CPU.
- starve_cnt: +1 (saturating at STARVE_MAX) on each ST_IDLE decision where dma_req=1 and CPU wins. Cleared when DMA is granted or when dma_req=0 in ST_IDLE.
- ST_ACCESS: mem_read = ~we, mem_write = we, mem_addr/mem_wdata stable for exactly MEM_LAT cycles. Counter decrements each cycle. On the counter==0 cycle, a read captures mem_rdata into the owner's rdata register; then go to ST_RESP.
- ST_RESP: strobes low; the owner's ack is high for exactly one cycle; the other requester's ack stays 0; return to ST_IDLE.
- Latency: req sampled at edge t gives strobes in cycles t+1..t+MEM_LAT, ack in cycle t+MEM_LAT+1, and the next grant sampled at the end of cycle t+MEM_LAT+2. Minimum throughput is one transaction per MEM_LAT+2 cycles.
- Handshake:
  - After grant, req/we/addr/wdata changes are ignored until ack.
  - A requester wanting no further access deasserts req in the cycle after ack. If req is still high in ST_IDLE, it is a new transaction.
  - A req dropped before grant is simply never served (no ack).
- Writes: the rdata registers are unchanged; mem_rdata is ignored.
- Simultaneous cpu_req and dma_req with starve_cnt < STARVE_MAX: CPU wins and starve_cnt increments.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding: ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2
  - owner encoding: OWN_CPU=1'b0, OWN_DMA=1'b1
- One sub-module: mem_arb_starve_ctr, a saturating counter with inc/clr inputs, a sat output and async active-high reset.
- Latency counter and FSM live in the top module.

Test Plan (MEM_LAT=2, STARVE_MAX=4):
- Reset mid-access: assert reset during the first strobe cycle of a CPU read -> mem_read drops at once, all outputs 0, no cpu_ack after release; next request proceeds normally.
- CPU read: cpu_req=1, cpu_we=0, addr=0x40, mem returns 0xDEADBEEF -> mem_read=1 for 2 cycles with mem_addr=0x40; cpu_ack pulses 1 cycle at t+3; cpu_rdata=0xDEADBEEF; dma_ack=0.
- DMA write: dma_we=1, addr=0x100, wdata=0x12345678 -> mem_write=1 for 2 cycles with that addr/data; dma_ack at t+3; owner=1; dma_rdata unchanged.
- Simultaneous requests: both reqs high, CPU re-requests after each ack -> CPU granted 4 times; DMA granted on the 5th arbitration; starve_cnt returns to 0.
- Mid-transaction change: cpu_addr changes from 0x40 to 0x80 during ST_ACCESS -> mem_addr stays 0x40 until ack.
- Early drop: dma_req pulsed 1 cycle while a CPU access is busy, then low -> DMA never granted, no dma_ack, starve_cnt cleared.
